// File: rtl/reg_file_unit.sv
// reg_file_unit: general registers A..D plus M1/M2 and X/Y (pairable as the
// 16-bit M and XY address registers at default width). Selects are
// combinational reads that are only driven when exactly one source is chosen.
// Strobe collisions latch a sticky conflict flag until clr_err.
module reg_file_unit #(
  parameter int DATA_W = 8,
  parameter int NUM_GP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [2*DATA_W-1:0]      addr_in,
  input  logic [NUM_GP-1:0]        ld_gp,
  input  logic [NUM_GP-1:0]        sel_gp,
  input  logic                     ld_m1,
  input  logic                     ld_m2,
  input  logic                     ld_x,
  input  logic                     ld_y,
  input  logic                     ld_xy,
  input  logic                     inc_xy,
  input  logic                     sel_m1,
  input  logic                     sel_m2,
  input  logic                     sel_x,
  input  logic                     sel_y,
  input  logic                     sel_m,
  input  logic                     sel_xy,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_oe,
  output logic [2*DATA_W-1:0]      addr_out,
  output logic                     addr_oe,
  output logic                     conflict,
  output logic [NUM_GP*DATA_W-1:0] gp_q
);

  localparam int ADDR_W = 2 * DATA_W;

  logic [DATA_W-1:0] gp_reg [NUM_GP];
  logic [DATA_W-1:0] gp_term [NUM_GP];
  logic [DATA_W-1:0] m1_reg, m2_reg, x_reg, y_reg;
  logic [DATA_W-1:0] x_next, y_next;
  logic              conflict_reg, conflict_next;

  logic [DATA_W-1:0] data_val;
  logic              data_any, data_multi;
  logic              addr_multi;
  logic              xy_conflict;
  logic [ADDR_W-1:0] xy_inc;

  // Per-register masked read terms and the flattened register view.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_GP; gi++) begin : g_gp
      assign gp_term[gi]                 = sel_gp[gi] ? gp_reg[gi] : '0;
      assign gp_q[gi*DATA_W +: DATA_W]   = gp_reg[gi];
    end
  endgenerate

  // Data bus: OR together selected sources and track whether more than one is chosen.
  always_comb begin
    data_any   = 1'b0;
    data_multi = 1'b0;
    data_val   = '0;
    for (int i = 0; i < NUM_GP; i++) begin
      if (sel_gp[i]) begin
        data_multi = data_multi | data_any;
        data_any   = 1'b1;
      end
      data_val = data_val | gp_term[i];
    end
    if (sel_m1) begin
      data_multi = data_multi | data_any;
      data_any   = 1'b1;
      data_val   = data_val | m1_reg;
    end
    if (sel_m2) begin
      data_multi = data_multi | data_any;
      data_any   = 1'b1;
      data_val   = data_val | m2_reg;
    end
    if (sel_x) begin
      data_multi = data_multi | data_any;
      data_any   = 1'b1;
      data_val   = data_val | x_reg;
    end
    if (sel_y) begin
      data_multi = data_multi | data_any;
      data_any   = 1'b1;
      data_val   = data_val | y_reg;
    end
  end

  assign data_oe  = data_any & ~data_multi;
  assign data_out = data_oe ? data_val : '0;

  // Address bus has only two sources, so a collision is simply both selected.
  assign addr_multi = sel_m & sel_xy;
  assign addr_oe    = sel_m ^ sel_xy;
  assign addr_out   = (sel_m & ~sel_xy) ? {m1_reg, m2_reg} :
                      (sel_xy & ~sel_m) ? {x_reg, y_reg}   : '0;

  assign xy_inc = {x_reg, y_reg} + ADDR_W'(1);

  // X/Y next value: full-pair load beats half loads, which beat increment.
  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (ld_xy) begin
      {x_next, y_next} = addr_in;
    end else if (ld_x | ld_y) begin
      if (ld_x) x_next = data_in;
      if (ld_y) y_next = data_in;
    end else if (inc_xy) begin
      {x_next, y_next} = xy_inc;
    end
    xy_conflict   = (ld_xy & (ld_x | ld_y)) | (inc_xy & (ld_xy | ld_x | ld_y));
    conflict_next = (conflict_reg & ~clr_err) | data_multi | addr_multi | xy_conflict;
  end

  // General registers: each captures data_in on its own load strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GP; i++) gp_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_GP; i++) begin
        if (ld_gp[i]) gp_reg[i] <= data_in;
      end
    end
  end

  // Pair registers and the sticky conflict flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_reg       <= '0;
      m2_reg       <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      conflict_reg <= 1'b0;
    end else begin
      if (ld_m1) m1_reg <= data_in;
      if (ld_m2) m2_reg <= data_in;
      x_reg        <= x_next;
      y_reg        <= y_next;
      conflict_reg <= conflict_next;
    end
  end

  assign conflict = conflict_reg;

endmodule

// File: tb/tb_reg_file_unit.sv
// Directed, table-driven bench for reg_file_unit at default parameters.
// Each vector: drive at negedge, check bus outputs before the edge, check
// conflict and general registers after the edge.
module tb_reg_file_unit;

  localparam logic [12:0] C_LM1 = 13'h0001;
  localparam logic [12:0] C_LM2 = 13'h0002;
  localparam logic [12:0] C_LX  = 13'h0004;
  localparam logic [12:0] C_LY  = 13'h0008;
  localparam logic [12:0] C_LXY = 13'h0010;
  localparam logic [12:0] C_INC = 13'h0020;
  localparam logic [12:0] C_SM1 = 13'h0040;
  localparam logic [12:0] C_SM2 = 13'h0080;
  localparam logic [12:0] C_SX  = 13'h0100;
  localparam logic [12:0] C_SY  = 13'h0200;
  localparam logic [12:0] C_SM  = 13'h0400;
  localparam logic [12:0] C_SXY = 13'h0800;
  localparam logic [12:0] C_CLR = 13'h1000;

  typedef struct packed {
    logic [3:0]  ld_gp;
    logic [3:0]  sel_gp;
    logic [12:0] ctl;
    logic [7:0]  din;
    logic [15:0] ain;
    logic [7:0]  e_dout;
    logic        e_doe;
    logic [15:0] e_aout;
    logic        e_aoe;
    logic        e_conf;
    logic [31:0] e_gp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic [15:0] addr_in;
  logic [3:0]  ld_gp, sel_gp;
  logic        ld_m1, ld_m2, ld_x, ld_y, ld_xy, inc_xy;
  logic        sel_m1, sel_m2, sel_x, sel_y, sel_m, sel_xy, clr_err;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [15:0] addr_out;
  logic        addr_oe;
  logic        conflict;
  logic [31:0] gp_q;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  reg_file_unit #(.DATA_W(8), .NUM_GP(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .addr_in(addr_in),
    .ld_gp(ld_gp), .sel_gp(sel_gp),
    .ld_m1(ld_m1), .ld_m2(ld_m2), .ld_x(ld_x), .ld_y(ld_y), .ld_xy(ld_xy), .inc_xy(inc_xy),
    .sel_m1(sel_m1), .sel_m2(sel_m2), .sel_x(sel_x), .sel_y(sel_y), .sel_m(sel_m), .sel_xy(sel_xy),
    .clr_err(clr_err), .data_out(data_out), .data_oe(data_oe),
    .addr_out(addr_out), .addr_oe(addr_oe), .conflict(conflict), .gp_q(gp_q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ld_gp   = v.ld_gp;
    sel_gp  = v.sel_gp;
    data_in = v.din;
    addr_in = v.ain;
    ld_m1   = v.ctl[0];
    ld_m2   = v.ctl[1];
    ld_x    = v.ctl[2];
    ld_y    = v.ctl[3];
    ld_xy   = v.ctl[4];
    inc_xy  = v.ctl[5];
    sel_m1  = v.ctl[6];
    sel_m2  = v.ctl[7];
    sel_x   = v.ctl[8];
    sel_y   = v.ctl[9];
    sel_m   = v.ctl[10];
    sel_xy  = v.ctl[11];
    clr_err = v.ctl[12];
  endtask

  initial begin
    vec_t idle;
    idle = '0;
    // ld_gp sel_gp ctl din ain | dout doe aout aoe | conf gp
    vecs.push_back('{4'h0, 4'h0, 13'h0,         8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h00000000});
    vecs.push_back('{4'h1, 4'h0, 13'h0,         8'h5A, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0000005A});
    vecs.push_back('{4'h0, 4'h1, 13'h0,         8'h00, 16'h0000, 8'h5A, 1'b1, 16'h0000, 1'b0, 1'b0, 32'h0000005A});
    vecs.push_back('{4'h2, 4'h0, 13'h0,         8'h11, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0000115A});
    vecs.push_back('{4'h2, 4'h2, 13'h0,         8'h33, 16'h0000, 8'h11, 1'b1, 16'h0000, 1'b0, 1'b0, 32'h0000335A});
    vecs.push_back('{4'h0, 4'h2, 13'h0,         8'h00, 16'h0000, 8'h33, 1'b1, 16'h0000, 1'b0, 1'b0, 32'h0000335A});
    vecs.push_back('{4'hC, 4'h0, 13'h0,         8'hC7, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h8, 13'h0,         8'h00, 16'h0000, 8'hC7, 1'b1, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_LM1,         8'h12, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_LM2|C_SM,    8'h34, 16'h0000, 8'h00, 1'b0, 16'h1200, 1'b1, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_SM|C_SM1,    8'h00, 16'h0000, 8'h12, 1'b1, 16'h1234, 1'b1, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_SM2,         8'h00, 16'h0000, 8'h34, 1'b1, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_LXY,         8'h00, 16'hFFFF, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_INC|C_SY,    8'h00, 16'h0000, 8'hFF, 1'b1, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_SXY,         8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_LX|C_LY,     8'h5C, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_SXY,         8'h00, 16'h0000, 8'h00, 1'b0, 16'h5C5C, 1'b1, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_SXY|C_SM,    8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_CLR,         8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h1, C_SX,          8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, 13'h0,         8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_CLR,         8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_LXY|C_LX|C_INC, 8'hAA, 16'h1234, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_SXY|C_CLR,   8'h00, 16'h0000, 8'h00, 1'b0, 16'h1234, 1'b1, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_CLR|C_INC|C_LY, 8'h77, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_SXY|C_CLR,   8'h00, 16'h0000, 8'h00, 1'b0, 16'h1277, 1'b1, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h4, 13'h0,         8'h00, 16'h0000, 8'hC7, 1'b1, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_LY,          8'hFF, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_INC|C_SXY,   8'h00, 16'h0000, 8'h00, 1'b0, 16'h12FF, 1'b1, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_SXY|C_SX,    8'h00, 16'h0000, 8'h13, 1'b1, 16'h1300, 1'b1, 1'b0, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h3, 13'h0,         8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hC7C7335A});
    vecs.push_back('{4'h0, 4'h0, C_CLR,         8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 32'hC7C7335A});

    // Power-on reset, checked before any clock edge.
    rst = 1'b1;
    drive(idle);
    #3;
    n_vec++;
    check("reset_gp_q", gp_q, 32'h0);
    check("reset_conflict", {31'b0, conflict}, 32'h0);
    check("reset_data_oe", {31'b0, data_oe}, 32'h0);
    check("reset_addr_oe", {31'b0, addr_oe}, 32'h0);
    $display("reset: gp_q=%h conflict=%b data_oe=%b addr_oe=%b", gp_q, conflict, data_oe, addr_oe);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      n_vec++;
      check($sformatf("v%0d_data_out", i), {24'b0, data_out}, {24'b0, vecs[i].e_dout});
      check($sformatf("v%0d_data_oe", i),  {31'b0, data_oe},  {31'b0, vecs[i].e_doe});
      check($sformatf("v%0d_addr_out", i), {16'b0, addr_out}, {16'b0, vecs[i].e_aout});
      check($sformatf("v%0d_addr_oe", i),  {31'b0, addr_oe},  {31'b0, vecs[i].e_aoe});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_conflict", i), {31'b0, conflict}, {31'b0, vecs[i].e_conf});
      check($sformatf("v%0d_gp_q", i), gp_q, vecs[i].e_gp);
      $display("vec %0d: data_out=%h/%b addr_out=%h/%b conflict=%b gp_q=%h",
               i, data_out, data_oe, addr_out, addr_oe, conflict, gp_q);
    end

    // Mid-cycle asynchronous reset with loaded registers and a set conflict.
    @(negedge clk);
    drive(idle);
    sel_gp = 4'b0011;
    @(posedge clk);
    #1;
    n_vec++;
    check("pre_rst_conflict", {31'b0, conflict}, 32'h1);
    $display("pre-reset: conflict=%b gp_q=%h", conflict, gp_q);
    #2;
    sel_gp  = 4'h0;
    ld_gp   = 4'hF;
    data_in = 8'hFF;
    ld_xy   = 1'b1;
    addr_in = 16'hABCD;
    sel_m   = 1'b1;
    rst     = 1'b1;
    #1;
    n_vec++;
    check("async_rst_gp_q", gp_q, 32'h0);
    check("async_rst_conflict", {31'b0, conflict}, 32'h0);
    check("async_rst_addr_out", {16'b0, addr_out}, 32'h0);
    check("async_rst_addr_oe", {31'b0, addr_oe}, 32'h1);
    $display("async reset: gp_q=%h conflict=%b addr_out=%h/%b", gp_q, conflict, addr_out, addr_oe);
    @(posedge clk);
    #1;
    n_vec++;
    check("rst_hold_gp_q", gp_q, 32'h0);
    $display("reset held over edge: gp_q=%h", gp_q);
    @(negedge clk);
    rst     = 1'b0;
    ld_gp   = 4'b0001;
    data_in = 8'h21;
    ld_xy   = 1'b0;
    sel_m   = 1'b0;
    sel_xy  = 1'b1;
    #1;
    n_vec++;
    check("post_rst_pre_edge_gp_q", gp_q, 32'h0);
    check("post_rst_xy", {16'b0, addr_out}, 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_first_load", gp_q, 32'h00000021);
    $display("after reset release: gp_q=%h addr_out=%h", gp_q, addr_out);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_unit.md
REG_FILE_UNIT -- requirements
Module: reg_file_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of every data register and the data bus.
REQ-002 SHALL have parameter NUM_GP, default 4, number of general registers (index 0..3 = A..D at default).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge active.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_in  input  DATA_W  data bus value presented to loads.
REQ-006 SHALL have port addr_in  input  2*DATA_W  address bus value presented to ld_xy.
REQ-007 SHALL have ports ld_gp, sel_gp  input  NUM_GP  per-register load/select strobes, bit i = register i.
REQ-008 SHALL have ports ld_m1, ld_m2, ld_x, ld_y, ld_xy, inc_xy  input  1 each  load/increment strobes.
REQ-009 SHALL have ports sel_m1, sel_m2, sel_x, sel_y, sel_m, sel_xy  input  1 each  bus select strobes.
REQ-010 SHALL have port clr_err  input  1  clears conflict flag.
REQ-011 SHALL have ports data_out  output  DATA_W  and data_oe  output  1  data bus drive value/enable.
REQ-012 SHALL have ports addr_out  output  2*DATA_W  and addr_oe  output  1  address bus drive value/enable.
REQ-013 SHALL have port conflict  output  1  sticky strobe-conflict flag.
REQ-014 SHALL have port gp_q  output  NUM_GP*DATA_W  registered contents of general registers, register i at bits [i*DATA_W +: DATA_W].

Function
REQ-015 Registers: NUM_GP general, M1, M2, X, Y, each DATA_W bits; M = {M1,M2}, XY = {X,Y} (M1, X high halves).
REQ-016 Any asserted ld_* SHALL capture data_in (addr_in for ld_xy) into its register(s) at the next rising clk; multiple data loads in one cycle all capture the same data_in.
REQ-017 Selects SHALL be combinational reads of current register contents; load and select of the same register in one cycle drives the old value, new value visible the following cycle.
REQ-018 Exactly one data select (sel_gp bits, sel_m1/m2/x/y) asserted: data_out = that register, data_oe = 1.
REQ-019 Zero data selects: data_out = 0, data_oe = 0.
REQ-020 Two or more data selects: data_out = 0, data_oe = 0, conflict set at next rising clk.
REQ-021 Address bus rules identical to REQ-018..020 over sel_m and sel_xy, driving addr_out/addr_oe.
REQ-022 inc_xy alone SHALL set XY <= XY + 1 modulo 2^(2*DATA_W); 0xFFFF wraps to 0x0000 at default.
REQ-023 Priority on X/Y: ld_xy > ld_x/ld_y > inc_xy; asserting ld_xy with ld_x or ld_y, or inc_xy with any X/Y load, SHALL apply only the winner and set conflict.
REQ-024 ld_x with ld_y (no ld_xy) is legal, both load data_in, no conflict.
REQ-025 conflict SHALL remain 1 until clr_err; clr_err in a cycle with a new conflict leaves conflict = 1.
REQ-026 Register contents SHALL never change except via REQ-016, REQ-022 or reset.

Reset
REQ-027 rst high SHALL immediately clear all registers to 0 and conflict to 0, independent of clk.
REQ-028 During reset data_oe and addr_oe follow REQ-018..021 on zeroed registers; strobes are ignored for state update.
REQ-029 rst asserted mid-cycle SHALL discard any pending load/increment; first update after deassertion is at the next rising clk.

Verification
REQ-030 ld_gp=0001, data_in=0x5A, then sel_gp=0001 -> data_out=0x5A, data_oe=1, gp_q[7:0]=0x5A.
REQ-031 Same cycle ld_gp=0010, sel_gp=0010, data_in=0x33 with B=0x11 -> data_out=0x11 that cycle, 0x33 next cycle.
REQ-032 ld_xy, addr_in=0xFFFF, then inc_xy one cycle, then sel_xy -> addr_out=0x0000, addr_oe=1, conflict=0.
REQ-033 sel_gp=0001 with sel_x=1 -> data_oe=0, data_out=0, conflict=1 after edge; persists until clr_err pulse -> 0.
REQ-034 ld_xy addr_in=0x1234 with ld_x data_in=0xAA and inc_xy -> XY=0x1234, conflict=1.
REQ-035 Load all registers nonzero, pulse rst between clock edges -> all registers, gp_q, conflict read 0 before next edge.
